// File: rtl/otp_serial_decipher.sv
// Bit-serial one-time-pad decipher: XORs an MSB-first ciphertext stream with a
// repeating key and emits plaintext bytes plus the assembled message.
module otp_serial_decipher #(
  parameter int BITS     = 64,
  parameter int KEY_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                bit_valid,
  input  logic                bit_in,
  output logic                busy,
  output logic                byte_valid,
  output logic [7:0]          byte_out,
  output logic                msg_done,
  output logic [BITS-1:0]     msg_out
);

  localparam int CW = $clog2(BITS + 1);
  localparam int KW = $clog2(KEY_BITS);

  // state | meaning
  // IDLE  | waiting for start; bit_valid ignored
  // RECV  | accepting ciphertext bits
  typedef enum logic {IDLE, RECV} state_t;

  state_t              state, state_nxt;
  logic [KEY_BITS-1:0] key_reg;
  logic [CW-1:0]       count;
  logic [KW-1:0]       key_idx;
  logic [7:0]          byte_sr;
  logic [BITS-1:0]     msg_sr;
  logic                byte_pend, msg_pend;
  logic                load, accept, last_bit, byte_end, plain_bit;

  assign busy      = (state == RECV);
  assign last_bit  = (count == CW'(BITS - 1));
  assign byte_end  = (count[2:0] == 3'b111);
  assign plain_bit = bit_in ^ key_reg[key_idx];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (bit_valid) begin
          accept = 1'b1;
          if (last_bit) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_reg    <= '0;
      count      <= '0;
      key_idx    <= '0;
      byte_sr    <= '0;
      msg_sr     <= '0;
      byte_pend  <= 1'b0;
      msg_pend   <= 1'b0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      msg_done   <= 1'b0;
      msg_out    <= '0;
    end else begin
      state      <= state_nxt;
      byte_valid <= byte_pend;
      msg_done   <= msg_pend;
      byte_pend  <= accept & byte_end;
      msg_pend   <= accept & last_bit;
      if (byte_pend) byte_out <= byte_sr;
      if (msg_pend)  msg_out  <= msg_sr;
      if (load) begin
        key_reg <= key_in;
        count   <= '0;
        key_idx <= KW'(KEY_BITS - 1);
        byte_sr <= '0;
        msg_sr  <= '0;
      end else if (accept) begin
        byte_sr <= {byte_sr[6:0], plain_bit};
        msg_sr  <= {msg_sr[BITS-2:0], plain_bit};
        count   <= count + CW'(1);
        // key bit index walks down from the key MSB and wraps per key period
        key_idx <= (key_idx == '0) ? KW'(KEY_BITS - 1) : key_idx - KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_otp_serial_decipher.sv
// Randomized and directed bench for otp_serial_decipher, checked against a
// repeated-key XOR reference model.
module tb_otp_serial_decipher;
  localparam int BITS     = 64;
  localparam int KEY_BITS = 32;
  localparam logic [31:0] KEY_NOM = 32'h66697665;
  localparam logic [63:0] CT_NOM  = 64'h031A021703051716;
  localparam logic [63:0] PT_NOM  = 64'h65737472656C6173;

  logic                clk = 1'b0;
  logic                rst, start, bit_valid, bit_in;
  logic [KEY_BITS-1:0] key_in;
  logic                busy, byte_valid, msg_done;
  logic [7:0]          byte_out;
  logic [BITS-1:0]     msg_out;

  otp_serial_decipher #(.BITS(BITS), .KEY_BITS(KEY_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy),
    .byte_valid(byte_valid), .byte_out(byte_out),
    .msg_done(msg_done), .msg_out(msg_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]      got_bytes[$];
  int              byte_cyc[$];
  logic [BITS-1:0] got_msgs[$];
  int              msg_cyc[$];

  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      got_bytes.push_back(byte_out);
      byte_cyc.push_back(cyc);
    end
    if (msg_done === 1'b1) begin
      got_msgs.push_back(msg_out);
      msg_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [BITS-1:0] ref_plain(input logic [KEY_BITS-1:0] key,
                                                 input logic [BITS-1:0] ct);
    logic [BITS-1:0] pad;
    for (int k = 0; k < BITS / KEY_BITS; k++) pad[k*KEY_BITS +: KEY_BITS] = key;
    return ct ^ pad;
  endfunction

  task automatic clear_logs();
    got_bytes.delete(); byte_cyc.delete(); got_msgs.delete(); msg_cyc.delete();
  endtask

  task automatic drive_start(input logic [KEY_BITS-1:0] key);
    start = 1'b1; key_in = key;
    @(posedge clk); #1;
    start = 1'b0; key_in = $urandom;
  endtask

  task automatic drive_bits(input logic [BITS-1:0] ct, input int first, input int last,
                            input int gmin, input int gmax);
    for (int i = first; i < last; i++) begin
      bit_valid = 1'b1; bit_in = ct[BITS-1-i];
      @(posedge clk); #1;
      bit_valid = 1'b0; bit_in = $urandom;
      repeat ($urandom_range(gmax, gmin)) begin @(posedge clk); #1; end
    end
    bit_valid = 1'b0;
  endtask

  task automatic wait_msgs(input string name, input int target);
    for (int i = 0; i < 40 && got_msgs.size() < target; i++) @(posedge clk);
    #1;
    total++;
    if (got_msgs.size() < target) begin
      bad++; $display("FAIL %s_timeout msgs=%0d need=%0d", name, got_msgs.size(), target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; key_in = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    total += 5;
    if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (byte_valid !== 1'b0) begin bad++; $display("FAIL rst_byte_valid got=%b exp=0", byte_valid); end
    if (byte_out !== 8'h00)  begin bad++; $display("FAIL rst_byte_out got=%h exp=00", byte_out); end
    if (msg_done !== 1'b0)   begin bad++; $display("FAIL rst_msg_done got=%b exp=0", msg_done); end
    if (msg_out !== '0)      begin bad++; $display("FAIL rst_msg_out got=%h exp=0", msg_out); end
  endtask

  task automatic test_nominal(input int gap);
    logic [BITS-1:0] exp;
    exp = ref_plain(KEY_NOM, CT_NOM);
    clear_logs();
    drive_start(KEY_NOM);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL nom_busy_after_start got=%b exp=1", busy); end
    drive_bits(CT_NOM, 0, BITS, gap, gap);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL nom_busy_after_last got=%b exp=0", busy); end
    wait_msgs("nominal", 1);
    repeat (5) @(posedge clk); #1;
    total += 4;
    if (got_bytes.size() != BITS / 8) begin bad++; $display("FAIL nom_byte_count got=%0d exp=%0d", got_bytes.size(), BITS / 8); end
    if (got_msgs.size() != 1) begin bad++; $display("FAIL nom_msg_count got=%0d exp=1", got_msgs.size()); end
    if (got_msgs.size() > 0 && got_msgs[0] !== PT_NOM) begin bad++; $display("FAIL nom_msg_out got=%h exp=%h", got_msgs[0], PT_NOM); end
    if (msg_cyc.size() > 0 && byte_cyc.size() == 8 && msg_cyc[0] != byte_cyc[7]) begin
      bad++; $display("FAIL nom_done_align got=%0d exp=%0d", msg_cyc[0], byte_cyc[7]);
    end
    for (int k = 0; k < BITS / 8; k++) begin
      logic [7:0] g, e;
      g = (k < got_bytes.size()) ? got_bytes[k] : 8'hxx;
      e = exp[BITS-1-8*k -: 8];
      total++;
      if (g !== e) begin bad++; $display("FAIL nom_byte%0d gap=%0d got=%h exp=%h", k, gap, g, e); end
    end
    for (int k = 0; k + 1 < byte_cyc.size(); k++) begin
      total++;
      if (byte_cyc[k+1] - byte_cyc[k] != 8 * (gap + 1)) begin
        bad++; $display("FAIL nom_spacing%0d got=%0d exp=%0d", k, byte_cyc[k+1] - byte_cyc[k], 8 * (gap + 1));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      logic [KEY_BITS-1:0] key;
      logic [BITS-1:0] ct, exp;
      key = $urandom; ct = {$urandom, $urandom};
      exp = ref_plain(key, ct);
      clear_logs();
      drive_start(key);
      drive_bits(ct, 0, BITS, 0, 2);
      wait_msgs("random", 1);
      total++;
      if (got_msgs.size() < 1 || got_msgs[0] !== exp) begin
        bad++; $display("FAIL rand%0d_msg got=%h exp=%h", r, (got_msgs.size() > 0) ? got_msgs[0] : 'x, exp);
      end
      for (int k = 0; k < BITS / 8; k++) begin
        logic [7:0] g;
        g = (k < got_bytes.size()) ? got_bytes[k] : 8'hxx;
        total++;
        if (g !== exp[BITS-1-8*k -: 8]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", r, k, g, exp[BITS-1-8*k -: 8]); end
      end
    end
  endtask

  task automatic test_zero_key();
    logic [BITS-1:0] ct;
    ct = 64'hFFFF0000AAAA5555;
    clear_logs();
    drive_start('0);
    drive_bits(ct, 0, BITS, 0, 0);
    wait_msgs("zero_key", 1);
    total++;
    if (got_msgs.size() < 1 || got_msgs[0] !== ct) begin
      bad++; $display("FAIL zero_key_msg got=%h exp=%h", (got_msgs.size() > 0) ? got_msgs[0] : 'x, ct);
    end
    for (int k = 0; k < BITS / 8; k++) begin
      logic [7:0] g;
      g = (k < got_bytes.size()) ? got_bytes[k] : 8'hxx;
      total++;
      if (g !== ct[BITS-1-8*k -: 8]) begin bad++; $display("FAIL zero_key_byte%0d got=%h exp=%h", k, g, ct[BITS-1-8*k -: 8]); end
    end
  endtask

  task automatic test_reset_mid(input int nbits);
    drive_start(KEY_NOM);
    drive_bits(CT_NOM, 0, nbits, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    total += 5;
    if (busy !== 1'b0)       begin bad++; $display("FAIL rstmid%0d_busy got=%b exp=0", nbits, busy); end
    if (byte_valid !== 1'b0) begin bad++; $display("FAIL rstmid%0d_byte_valid got=%b exp=0", nbits, byte_valid); end
    if (byte_out !== 8'h00)  begin bad++; $display("FAIL rstmid%0d_byte_out got=%h exp=00", nbits, byte_out); end
    if (msg_done !== 1'b0)   begin bad++; $display("FAIL rstmid%0d_msg_done got=%b exp=0", nbits, msg_done); end
    if (msg_out !== '0)      begin bad++; $display("FAIL rstmid%0d_msg_out got=%h exp=0", nbits, msg_out); end
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1; bit_in = $urandom;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    total++;
    if (got_bytes.size() + got_msgs.size() != 0) begin
      bad++; $display("FAIL rstmid%0d_pulses got=%0d exp=0", nbits, got_bytes.size() + got_msgs.size());
    end
    clear_logs();
    drive_start(KEY_NOM);
    drive_bits(CT_NOM, 0, BITS, 0, 0);
    wait_msgs("reset_mid", 1);
    total += 2;
    if (got_msgs.size() < 1 || got_msgs[0] !== PT_NOM) begin
      bad++; $display("FAIL rstmid%0d_resume got=%h exp=%h", nbits, (got_msgs.size() > 0) ? got_msgs[0] : 'x, PT_NOM);
    end
    if (got_bytes.size() != 8) begin bad++; $display("FAIL rstmid%0d_resume_bytes got=%0d exp=8", nbits, got_bytes.size()); end
  endtask

  task automatic test_ignored();
    clear_logs();
    drive_start(KEY_NOM);
    drive_bits(CT_NOM, 0, 30, 0, 1);
    start = 1'b1; key_in = '1;
    drive_bits(CT_NOM, 30, 36, 0, 1);
    start = 1'b0;
    drive_bits(CT_NOM, 36, BITS, 0, 1);
    wait_msgs("ignored", 1);
    total++;
    if (got_msgs.size() < 1 || got_msgs[0] !== PT_NOM) begin
      bad++; $display("FAIL ign_start_msg got=%h exp=%h", (got_msgs.size() > 0) ? got_msgs[0] : 'x, PT_NOM);
    end
    repeat (3) @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 24; i++) begin
      bit_valid = $urandom; bit_in = $urandom;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle_busy%0d got=%b exp=0", i, busy); end
    end
    bit_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    total += 2;
    if (got_bytes.size() + got_msgs.size() != 0) begin
      bad++; $display("FAIL ign_idle_pulses got=%0d exp=0", got_bytes.size() + got_msgs.size());
    end
    if (msg_out !== PT_NOM) begin bad++; $display("FAIL ign_idle_msg_hold got=%h exp=%h", msg_out, PT_NOM); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    drive_start(KEY_NOM);
    drive_bits(CT_NOM, 0, BITS, 0, 0);
    @(posedge clk); #1;
    drive_start(KEY_NOM);
    drive_bits(CT_NOM, 0, BITS, 0, 0);
    wait_msgs("b2b", 2);
    total += 4;
    if (got_msgs.size() != 2) begin bad++; $display("FAIL b2b_msg_count got=%0d exp=2", got_msgs.size()); end
    if (got_bytes.size() != 16) begin bad++; $display("FAIL b2b_byte_count got=%0d exp=16", got_bytes.size()); end
    if (got_msgs.size() == 2 && got_msgs[1] !== PT_NOM) begin
      bad++; $display("FAIL b2b_msg2 got=%h exp=%h", got_msgs[1], PT_NOM);
    end
    if (msg_cyc.size() == 2 && msg_cyc[1] - msg_cyc[0] != BITS + 2) begin
      bad++; $display("FAIL b2b_period got=%0d exp=%0d", msg_cyc[1] - msg_cyc[0], BITS + 2);
    end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] g;
      g = (k + 8 < got_bytes.size()) ? got_bytes[k+8] : 8'hxx;
      total++;
      if (g !== PT_NOM[BITS-1-8*k -: 8]) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", k, g, PT_NOM[BITS-1-8*k -: 8]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal(0);
    test_nominal(3);
    test_zero_key();
    test_random();
    test_reset_mid(20);
    test_reset_mid(24);
    test_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
